// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding and default
// vector layout.
package int_ctrl_pkg;
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam logic [15:0] VEC_BASE_DEF   = 16'h0002;
    localparam logic [15:0] VEC_STRIDE_DEF = 16'h0004;
    localparam int          ID_W           = 4;
endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag.
module prio_enc #(
    parameter int W     = 8,
    parameter int IDX_W = 4
) (
    input  logic [W-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);
    // Scanning from the top lets the lowest set index overwrite last.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        for (int j = W - 1; j >= 0; j--) begin
            if (req[j]) begin
                idx = IDX_W'(j);
                vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/int_ctrl.sv
// Prioritised interrupt controller: edge/level pending capture, strict
// preemption against in-service channels, ack/EOI handshake.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int                NUM_IRQ    = 8,
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(VEC_BASE_DEF),
    parameter logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(VEC_STRIDE_DEF)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_ce,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic [NUM_IRQ-1:0] i_mask,
    input  logic [NUM_IRQ-1:0] i_edge,
    input  logic               i_ack,
    input  logic               i_eoi,
    output logic               o_irq,
    output logic [ADDR_W-1:0]  o_vector,
    output logic [3:0]         o_id,
    output logic [NUM_IRQ-1:0] o_pending,
    output logic [NUM_IRQ-1:0] o_isr,
    output logic               o_eoi_err
);
    state_t             state, state_nxt;
    logic               irq_nxt;
    logic [ID_W-1:0]    id_nxt, cand_id, eoi_id;
    logic [ADDR_W-1:0]  vec_nxt, cand_vec;
    logic               cand_vld, eoi_vld, ack_go, cur_masked, cur_drop;
    logic [NUM_IRQ-1:0] irq_q, below_isr, eligible, id_oh, ack_set, eoi_clr;
    logic [NUM_IRQ-1:0] rise, pend_nxt, isr_nxt;

    // A channel may preempt only if it is strictly above every in-service bit.
    always_comb begin
        logic seen;
        seen      = 1'b0;
        below_isr = '0;
        for (int j = 0; j < NUM_IRQ; j++) begin
            seen         = seen | o_isr[j];
            below_isr[j] = ~seen;
        end
    end

    assign eligible = o_pending & ~i_mask & below_isr;

    prio_enc #(.W(NUM_IRQ), .IDX_W(ID_W)) u_cand (.req(eligible), .idx(cand_id), .vld(cand_vld));
    prio_enc #(.W(NUM_IRQ), .IDX_W(ID_W)) u_eoi  (.req(o_isr),    .idx(eoi_id),  .vld(eoi_vld));

    assign cand_vec = VEC_BASE + ADDR_W'(cand_id) * VEC_STRIDE;

    always_comb begin
        id_oh   = '0;
        eoi_clr = '0;
        for (int j = 0; j < NUM_IRQ; j++) begin
            id_oh[j]   = (o_id == ID_W'(j));
            eoi_clr[j] = i_eoi && eoi_vld && (eoi_id == ID_W'(j));
        end
    end

    assign ack_go     = i_ack && (state == REQ);
    assign ack_set    = ack_go ? id_oh : '0;
    assign cur_masked = |(id_oh & i_mask);
    assign cur_drop   = |(id_oh & ~i_edge & ~o_pending);

    always_comb begin
        state_nxt = state;
        irq_nxt   = o_irq;
        id_nxt    = o_id;
        vec_nxt   = o_vector;
        case (state)
            IDLE: if (cand_vld) begin
                state_nxt = REQ;
                irq_nxt   = 1'b1;
                id_nxt    = cand_id;
                vec_nxt   = cand_vec;
            end
            REQ: if (i_ack || cur_masked || cur_drop) begin
                state_nxt = IDLE;
                irq_nxt   = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            o_irq    <= 1'b0;
            o_id     <= '0;
            o_vector <= '0;
        end else if (i_ce) begin
            state    <= state_nxt;
            o_irq    <= irq_nxt;
            o_id     <= id_nxt;
            o_vector <= vec_nxt;
        end
    end

    // Edge set beats ack clear; level channels simply track the sampled line.
    assign rise     = i_irq & ~irq_q;
    assign pend_nxt = (i_edge & ((o_pending & ~ack_set) | rise)) | (~i_edge & i_irq);
    assign isr_nxt  = (o_isr & ~eoi_clr) | ack_set;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            irq_q     <= '0;
            o_pending <= '0;
            o_isr     <= '0;
            o_eoi_err <= 1'b0;
        end else if (i_ce) begin
            irq_q     <= i_irq;
            o_pending <= pend_nxt;
            o_isr     <= isr_nxt;
            o_eoi_err <= i_eoi && !eoi_vld;
        end
    end
endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: channel-level reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_int_ctrl;
    logic        i_clk = 1'b0;
    logic        i_rst_n, i_ce, i_ack, i_eoi;
    logic [7:0]  i_irq, i_mask, i_edge;
    logic        o_irq, o_eoi_err;
    logic [15:0] o_vector;
    logic [3:0]  o_id;
    logic [7:0]  o_pending, o_isr;

    int n_cmp = 0;
    int n_bad = 0;

    int_ctrl dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_ce), .i_irq(i_irq),
        .i_mask(i_mask), .i_edge(i_edge), .i_ack(i_ack), .i_eoi(i_eoi),
        .o_irq(o_irq), .o_vector(o_vector), .o_id(o_id),
        .o_pending(o_pending), .o_isr(o_isr), .o_eoi_err(o_eoi_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: per-channel bookkeeping of what the CPU should see.
    logic       m_pres, m_err;
    logic [3:0] m_id;
    logic [15:0] m_vec;
    logic [7:0] m_pend, m_isr, m_prev, n_pend, n_isr;
    int         lo_isr, cand;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_pres = 0; m_err = 0; m_id = 0; m_vec = 0;
            m_pend = 0; m_isr = 0; m_prev = 0;
        end else if (i_ce) begin
            lo_isr = 8;
            for (int j = 7; j >= 0; j--) if (m_isr[j]) lo_isr = j;
            cand = -1;
            for (int j = 7; j >= 0; j--)
                if (m_pend[j] && !i_mask[j] && j < lo_isr) cand = j;
            n_isr = m_isr;
            m_err = 0;
            if (i_eoi) begin
                if (lo_isr == 8) m_err = 1;
                else n_isr[lo_isr] = 0;
            end
            for (int j = 0; j < 8; j++) n_pend[j] = i_edge[j] ? m_pend[j] : i_irq[j];
            if (m_pres) begin
                if (i_ack) begin
                    n_isr[m_id] = 1;
                    if (i_edge[m_id]) n_pend[m_id] = 0;
                    m_pres = 0;
                end else if (i_mask[m_id] || (!i_edge[m_id] && !m_pend[m_id])) begin
                    m_pres = 0;
                end
            end else if (cand >= 0) begin
                m_pres = 1;
                m_id   = 4'(cand);
                m_vec  = 16'(2 + cand * 4);
            end
            for (int j = 0; j < 8; j++)
                if (i_edge[j] && i_irq[j] && !m_prev[j]) n_pend[j] = 1;
            m_prev = i_irq;
            m_pend = n_pend;
            m_isr  = n_isr;
        end
    end

    always @(negedge i_clk) begin
        chk("m_irq", 32'(o_irq), 32'(m_pres));
        chk("m_vector", 32'(o_vector), 32'(m_vec));
        chk("m_id", 32'(o_id), 32'(m_id));
        chk("m_pending", 32'(o_pending), 32'(m_pend));
        chk("m_isr", 32'(o_isr), 32'(m_isr));
        chk("m_eoi_err", 32'(o_eoi_err), 32'(m_err));
    end

    task automatic cyc(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(negedge i_clk);
            #1;
        end
    endtask

    task automatic pulse_ack();
        i_ack = 1; cyc(); i_ack = 0;
    endtask

    task automatic pulse_eoi();
        i_eoi = 1; cyc(); i_eoi = 0;
    endtask

    initial begin
        i_rst_n = 0; i_ce = 1; i_ack = 0; i_eoi = 0;
        i_irq = 0; i_mask = 0; i_edge = 8'hEF;
        cyc(2);
        chk("rst_irq", 32'(o_irq), 0);
        chk("rst_vector", 32'(o_vector), 0);
        chk("rst_isr", 32'(o_isr), 0);
        i_rst_n = 1;
        cyc();

        // Edge ch3: two cycles to request, ack moves it to in-service.
        i_irq[3] = 1; cyc();
        chk("a_pend", 32'(o_pending), 32'h08);
        chk("a_irq_early", 32'(o_irq), 0);
        cyc();
        chk("a_irq", 32'(o_irq), 1);
        chk("a_vec", 32'(o_vector), 32'h000E);
        chk("a_id", 32'(o_id), 3);
        pulse_ack();
        chk("a_isr", 32'(o_isr), 32'h08);
        chk("a_pend_clr", 32'(o_pending), 0);
        chk("a_irq_low", 32'(o_irq), 0);
        i_irq = 0;

        // Lower priority blocked; higher priority preempts.
        i_irq[5] = 1; cyc(3);
        chk("b_blocked", 32'(o_irq), 0);
        i_irq[1] = 1; cyc(2);
        chk("b_vec1", 32'(o_vector), 32'h0006);
        pulse_ack();
        chk("b_isr", 32'(o_isr), 32'h0A);
        pulse_eoi();
        chk("b_eoi", 32'(o_isr), 32'h08);
        pulse_eoi(); cyc();
        chk("b_vec5", 32'(o_vector), 32'h0016);
        pulse_ack(); pulse_eoi();
        i_irq = 0;

        // Simultaneous edges: ch2 first, ch6 only after its EOI.
        i_irq[2] = 1; i_irq[6] = 1; cyc(2);
        chk("c_vec2", 32'(o_vector), 32'h000A);
        pulse_ack();
        chk("c_isr", 32'(o_isr), 32'h04);
        pulse_eoi(); cyc();
        chk("c_vec6", 32'(o_vector), 32'h001A);
        chk("c_irq6", 32'(o_irq), 1);
        pulse_ack(); pulse_eoi();
        i_irq = 0;

        // Level ch4 retracted by masking before ack.
        i_irq[4] = 1; cyc(2);
        chk("d_vec4", 32'(o_vector), 32'h0012);
        i_mask[4] = 1; cyc();
        chk("d_retract", 32'(o_irq), 0);
        chk("d_isr", 32'(o_isr), 0);
        i_irq[4] = 0; cyc();
        i_mask = 0; cyc();

        // EOI error pulse, then EOI+ack ordering.
        pulse_eoi();
        chk("e_err", 32'(o_eoi_err), 1);
        cyc();
        chk("e_err_clr", 32'(o_eoi_err), 0);
        i_irq[2] = 1; cyc(2); pulse_ack();
        chk("e_isr4", 32'(o_isr), 32'h04);
        i_irq[0] = 1; cyc(2);
        chk("e_vec0", 32'(o_vector), 32'h0002);
        i_ack = 1; i_eoi = 1; cyc(); i_ack = 0; i_eoi = 0;
        chk("e_isr1", 32'(o_isr), 32'h01);
        pulse_eoi();
        i_irq = 0;

        // Clock-enable freeze mid-request, then async reset mid-request.
        i_irq[7] = 1; cyc(2);
        chk("f_vec7", 32'(o_vector), 32'h001E);
        i_ce = 0; i_ack = 1; i_eoi = 1; cyc(5); i_ack = 0; i_eoi = 0;
        chk("f_frz_irq", 32'(o_irq), 1);
        chk("f_frz_vec", 32'(o_vector), 32'h001E);
        chk("f_frz_pend", 32'(o_pending), 32'h80);
        chk("f_frz_isr", 32'(o_isr), 0);
        i_ce = 1;
        pulse_ack();
        chk("f_isr", 32'(o_isr), 32'h80);
        i_irq[0] = 1; cyc(2);
        chk("f_irq0", 32'(o_irq), 1);
        i_rst_n = 0; #2;
        chk("f_rst_irq", 32'(o_irq), 0);
        chk("f_rst_isr", 32'(o_isr), 0);
        chk("f_rst_pend", 32'(o_pending), 0);
        cyc(2);
        i_irq = 0; i_rst_n = 1;
        cyc(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
